pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Hazard and stall sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects load-use hazards and inserts one bubble.
- Holds EX for the full occupancy of multi-cycle ALU ops (mult/div).
- Squashes the three younger instructions when a branch resolves taken in MEM.
- Drives the write-enable, flush and hold controls of PC, IF_ID, ID/EX and EX/MEM.

Parameters:
- MC_LATENCY, 4: cycles a multi-cycle op occupies EX. Legal range is 1..8.
- CNT_W, 3: width of the multi-cycle down-counter.
- STALL_W, 16: width of the stall-cycle statistics counter.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ID_Rs  in  5  rs field of instruction in ID.
- ID_Rt  in  5  rt field of instruction in ID.
- ID_UsesRs  in  1  ID instruction reads rs.
- ID_UsesRt  in  1  ID instruction reads rt.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_WriteReg  in  5  destination register of the EX instruction (post RegDst mux).
- EX_MultiCycle  in  1  instruction in EX is a multi-cycle op.
- M_BranchCon  in  1  branch in MEM resolved taken.
- PCWrite  out  1  PC load enable.
- IF_ID_Write  out  1  IF_ID register load enable.
- IF_ID_Flush  out  1  clear IF_ID to NOP.
- ID_EX_Bubble  out  1  load zeroed controls into ID/EX.
- EX_MEM_Flush  out  1  load zeroed controls into EX_MEM.
- EX_Hold  out  1  freeze ID/EX register and EX-stage operands.
- MC_Busy  out  1  multi-cycle op in progress.
- StallCycles  out  STALL_W  count of cycles with PCWrite=0.

Behaviour:
- States: RUN, MC_BUSY. Any other encoding recovers to RUN on the next edge.
- Control outputs are combinational from state, counter and inputs. State, counter and StallCycles are registered.
- Reset low (asynchronous) forces:
  - state=RUN, cnt=0, StallCycles=0.
  - PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, EX_MEM_Flush=1, EX_Hold=0, MC_Busy=0.
  - Reset asserted mid-MC_BUSY aborts the op immediately.
- Default outputs (no event): PCWrite=1, IF_ID_Write=1, all flush/bubble/hold=0.
- load_use = EX_MemRead & (EX_WriteReg!=0) & ((ID_UsesRs & ID_Rs==EX_WriteReg) | (ID_UsesRt & ID_Rt==EX_WriteReg)).
- RUN, priority highest first:
  1. M_BranchCon=1: IF_ID_Flush=1, ID_EX_Bubble=1, EX_MEM_Flush=1, PCWrite=1 (PC takes the branch target), next=RUN. Masks multi-cycle start and load_use in the same cycle.
  2. EX_MultiCycle=1 and MC_LATENCY>1: PCWrite=0, IF_ID_Write=0, EX_Hold=1, EX_MEM_Flush=1, MC_Busy=1; cnt<=MC_LATENCY-2; next=MC_BUSY.
  3. load_use=1: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; next=RUN. The single bubble clears the hazard; no extra state.
  4. MC_LATENCY=1: a multi-cycle op never stalls.
- MC_BUSY:
  - cnt!=0: same hold outputs as RUN case 2; cnt<=cnt-1.
  - cnt==0 (release cycle): default outputs, MC_Busy=1, EX result passes to EX_MEM; next=RUN. EX_MultiCycle still high in this cycle must not retrigger.
  - EX occupancy = MC_LATENCY cycles: MC_LATENCY-1 hold cycles plus the release cycle.
  - load_use is ignored in MC_BUSY.
  - M_BranchCon=1 in MC_BUSY (abnormal): apply the branch flush outputs, EX_Hold=0, cnt<=0, next=RUN.
- StallCycles increments on each edge where PCWrite=0 and Reset is high. It saturates at all-ones.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - hazard state enum (RUN, MC_BUSY);
  - MC_LATENCY default;
  - register-index width constant (5);
  - $zero index constant.
- One combinational sub-module, load_use_detect, produces load_use from the ID/EX fields. It is reusable by the forwarding logic.

Test Plan:
1. Load-use: Reset high; EX_MemRead=1, EX_WriteReg=8, ID_Rs=8, ID_UsesRs=1 for one cycle, then EX_MemRead=0 -> exactly one cycle of PCWrite=0/IF_ID_Write=0/ID_EX_Bubble=1, then default outputs; StallCycles=1.
2. $zero and unused-operand cases: EX_WriteReg=0 with ID_Rs=0; and EX_WriteReg=9, ID_Rt=9, ID_UsesRt=0 -> no stall, outputs default.
3. Multi-cycle: MC_LATENCY=4, EX_MultiCycle=1 held -> 3 cycles EX_Hold=1/PCWrite=0/EX_MEM_Flush=1, 4th cycle release with MC_Busy=1 and default controls, then RUN; StallCycles=3.
4. Priority: M_BranchCon=1 together with EX_MultiCycle=1 and load_use=1 -> only the triple flush with PCWrite=1; state stays RUN; StallCycles unchanged.
5. Abort by branch: M_BranchCon=1 during MC_BUSY with cnt=1 -> flush outputs, EX_Hold=0, RUN next cycle.
6. Reset during MC_BUSY: drive Reset=0 mid-op -> outputs switch to reset values without waiting for a clock edge; after release, RUN with StallCycles=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/stall control slice.
// Imported by the hazard sequencer and the load-use detector.
package pipe_ctrl_pkg;

  localparam int REG_W          = 5;
  localparam int MC_LATENCY_DEF = 4;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_BUSY = 2'd1
  } hz_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect between the ID instruction and a load in EX.
// Pure combinational so the forwarding logic can reuse it.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_write_reg,
  output logic             load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs && (id_rs == ex_write_reg);
  assign rt_hit = id_uses_rt && (id_rt == ex_write_reg);

  // $zero is never a real producer, so it never stalls
  assign load_use = ex_mem_read
                 && (ex_write_reg != REG_ZERO)
                 && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: load-use bubble,
// multi-cycle EX hold, taken-branch squash and stall statistics.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LATENCY = MC_LATENCY_DEF,
  parameter int CNT_W      = 3,
  parameter int STALL_W    = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [REG_W-1:0]   ID_Rs,
  input  logic [REG_W-1:0]   ID_Rt,
  input  logic               ID_UsesRs,
  input  logic               ID_UsesRt,
  input  logic               EX_MemRead,
  input  logic [REG_W-1:0]   EX_WriteReg,
  input  logic               EX_MultiCycle,
  input  logic               M_BranchCon,
  output logic               PCWrite,
  output logic               IF_ID_Write,
  output logic               IF_ID_Flush,
  output logic               ID_EX_Bubble,
  output logic               EX_MEM_Flush,
  output logic               EX_Hold,
  output logic               MC_Busy,
  output logic [STALL_W-1:0] StallCycles
);

  localparam logic [CNT_W-1:0] MC_RELOAD =
    (MC_LATENCY > 1) ? CNT_W'(MC_LATENCY - 2) : '0;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               load_use;

  load_use_detect u_lud (
    .id_rs        (ID_Rs),
    .id_rt        (ID_Rt),
    .id_uses_rs   (ID_UsesRs),
    .id_uses_rt   (ID_UsesRt),
    .ex_mem_read  (EX_MemRead),
    .ex_write_reg (EX_WriteReg),
    .load_use     (load_use)
  );

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    EX_MEM_Flush = 1'b0;
    EX_Hold      = 1'b0;
    MC_Busy      = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    case (state_q)
      RUN: begin
        if (M_BranchCon) begin
          IF_ID_Flush  = 1'b1;
          ID_EX_Bubble = 1'b1;
          EX_MEM_Flush = 1'b1;
        end else if (EX_MultiCycle && (MC_LATENCY > 1)) begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          EX_Hold      = 1'b1;
          EX_MEM_Flush = 1'b1;
          MC_Busy      = 1'b1;
          cnt_d        = MC_RELOAD;
          state_d      = MC_BUSY;
        end else if (load_use) begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
        end
      end
      MC_BUSY: begin
        if (M_BranchCon) begin
          IF_ID_Flush  = 1'b1;
          ID_EX_Bubble = 1'b1;
          EX_MEM_Flush = 1'b1;
          cnt_d        = '0;
          state_d      = RUN;
        end else if (cnt_q != '0) begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          EX_Hold      = 1'b1;
          EX_MEM_Flush = 1'b1;
          MC_Busy      = 1'b1;
          cnt_d        = cnt_q - CNT_W'(1);
        end else begin
          // release: EX result flows into EX_MEM this cycle
          MC_Busy      = 1'b1;
          state_d      = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    if (!Reset) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      EX_MEM_Flush = 1'b1;
      EX_Hold      = 1'b0;
      MC_Busy      = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!PCWrite && (stall_q != '1))
      stall_d = stall_q + STALL_W'(1);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign StallCycles = stall_q;

endmodule
